// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Imported by the fetch top, its FIFO and the bus interface.
package inst_fetch_pkg;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic        Stop        = 1'b1;
    localparam logic        NoStop      = 1'b0;
    localparam logic        RstEnable   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction bus: single-outstanding req/gnt request phase
// followed by an rvalid response phase.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic                   ibus_req_o;
    logic [InstAddrBus-1:0] ibus_addr_o;
    logic                   ibus_gnt_i;
    logic                   ibus_rvalid_i;
    logic [InstBus-1:0]     ibus_rdata_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_gnt_i,
        input  ibus_rvalid_i,
        input  ibus_rdata_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_gnt_i,
        output ibus_rvalid_i,
        output ibus_rdata_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, inst} entries with flush.
// Head is read combinationally; flush beats push and pop.
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [AW:0]  count,
    output logic         empty
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   wptr;
    logic            push_ok;
    logic            pop_ok;

    assign empty   = (count == '0);
    assign push_ok = push && (count != FULL) && !flush
                     && (rst != RstEnable);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential PC, single-outstanding bus
// requests, prefetch queue and redirect handling.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   redirect_i,
    input  logic [InstAddrBus-1:0] redirect_pc_i,
    inst_fetch_if.master           ibus,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    output logic                   if_valid
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_state_t           state;
    fetch_state_t           state_nxt;
    logic [InstAddrBus-1:0] fetch_pc;
    logic [InstAddrBus-1:0] req_pc;
    logic [AW:0]            count;
    logic                   empty;
    fetch_entry_t           head;
    fetch_entry_t           din;
    logic                   req;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   unused_stall;

    assign unused_stall = ^{stall[5:2], stall[0]};

    assign if_valid = !empty;
    assign pop      = if_valid && (stall[1] != Stop);

    assign req    = (state == ST_IDLE) && (rst != RstEnable)
                    && (count < FULL) && !redirect_i;
    assign accept = req && ibus.ibus_gnt_i;

    // A response racing a redirect belongs to the old stream.
    assign push = (state == ST_WAIT) && ibus.ibus_rvalid_i
                  && !redirect_i;

    assign din.pc   = req_pc;
    assign din.inst = ibus.ibus_rdata_i;

    assign ibus.ibus_req_o  = req;
    assign ibus.ibus_addr_o = fetch_pc;

    assign if_pc   = if_valid ? head.pc   : ZeroWord;
    assign if_inst = if_valid ? head.inst : ZeroWord;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = redirect_i ? ST_DISCARD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ibus.ibus_rvalid_i) begin
                    state_nxt = ST_IDLE;
                end else if (redirect_i) begin
                    state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (ibus.ibus_rvalid_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect_i) begin
                fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            end else if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (accept) begin
                req_pc <= fetch_pc;
            end
        end
    end

    // Flush on redirect: a head popped this cycle is the delay slot.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   (din),
        .head  (head),
        .count (count),
        .empty (empty)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: bus slave model, PC-stream
// reference model and a scoreboard fed at every pop.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    inst_fetch_if ibus();

    inst_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ibus          (ibus.master),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_pops = 0;

    // Reference: the ordered PCs the pipeline must see.
    logic [31:0] exp_q[$];
    logic [31:0] seg_next;

    // Bus slave state.
    int          gnt_max = 0;
    int          rv_max = 0;
    int          gnt_cnt = 0;
    bit          pend = 0;
    bit          pend_stray = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    bit          held_valid = 0;
    logic [31:0] held_addr = '0;

    bit          chk_due = 0;
    bit          exp_req = 0;
    logic [31:0] exp_addr = '0;
    bit          first_req = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(seg_next);
            seg_next = seg_next + 32'd4;
        end
    endtask

    task automatic reseed(input logic [31:0] pc);
        exp_q.delete();
        seg_next = pc;
        refill();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        stall = '0;
        redirect_i = 1'b0;
        ibus.ibus_gnt_i = 1'b0;
        ibus.ibus_rvalid_i = 1'b0;
        chk_due = 0;
        held_valid = 0;
        if (pend) begin
            pend_stray = 1;
            if (pend_cnt == 0) pend_cnt = 1;
        end
        @(posedge clk);
        #1;
        check("rst_req", {31'b0, ibus.ibus_req_o}, 32'd0);
        check("rst_addr", ibus.ibus_addr_o, RESET_PC);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_inst", if_inst, 32'd0);
        reseed(RESET_PC);
        first_req = 1;
    endtask

    task automatic cycle(input int stall_pct, input int redir_pct);
        logic [31:0] head;
        logic        rv;
        logic        gnt;
        bit          chk_set;
        chk_set = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rv = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                rv = 1'b1;
                pend = 0;
            end else begin
                pend_cnt--;
            end
        end
        ibus.ibus_rvalid_i = rv;
        ibus.ibus_rdata_i = rv ? pend_data : $urandom;
        stall = 6'($urandom);
        stall[1] = ($urandom_range(99, 0) < stall_pct);
        redirect_i = 1'b0;
        redirect_pc_i = $urandom;
        refill();
        if (!chk_due && if_valid && !stall[1]
            && ($urandom_range(99, 0) < redir_pct)) begin
            redirect_i = 1'b1;
            redirect_pc_i = 32'h100 + ($urandom_range(255, 0) << 2);
            head = exp_q[0];
            reseed(redirect_pc_i);
            exp_q.push_front(head);
            chk_set = 1;
            exp_req = !(pend && !pend_stray);
            exp_addr = redirect_pc_i;
        end
        #1;
        if (first_req) begin
            first_req = 0;
            check("first_req", {31'b0, ibus.ibus_req_o}, 32'd1);
            check("first_addr", ibus.ibus_addr_o, RESET_PC);
        end
        if (chk_due) begin
            check("redir_req", {31'b0, ibus.ibus_req_o},
                  {31'b0, exp_req});
            if (exp_req) begin
                check("redir_addr", ibus.ibus_addr_o, exp_addr);
            end
        end
        chk_due = chk_set;
        if (held_valid && ibus.ibus_req_o) begin
            check("addr_stable", ibus.ibus_addr_o, held_addr);
        end
        gnt = 1'b0;
        if (ibus.ibus_req_o && !pend) begin
            if (gnt_cnt == 0) begin
                gnt = 1'b1;
                pend = 1;
                pend_stray = 0;
                pend_cnt = $urandom_range(rv_max, 0);
                pend_data = ibus.ibus_addr_o ^ 32'h0000_FFFF;
                gnt_cnt = $urandom_range(gnt_max, 0);
            end else begin
                gnt_cnt--;
            end
        end
        ibus.ibus_gnt_i = gnt;
        held_valid = ibus.ibus_req_o && !gnt;
        held_addr = ibus.ibus_addr_o;
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (if_valid && !stall[1]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_extra: got pc %h expected none",
                             if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e);
                    check("if_inst", if_inst, e ^ 32'h0000_FFFF);
                    n_pops++;
                end
            end else if (!if_valid) begin
                check("empty_pc", if_pc, 32'd0);
                check("empty_inst", if_inst, 32'd0);
            end
        end
    end

    initial begin
        int  p0;
        bit  found;
        ibus.ibus_gnt_i = 1'b0;
        ibus.ibus_rvalid_i = 1'b0;
        ibus.ibus_rdata_i = '0;
        reseed(RESET_PC);

        do_reset();

        gnt_max = 0;
        rv_max = 0;
        p0 = n_pops;
        repeat (40) cycle(0, 0);
        check("stream_rate", {31'b0, (n_pops - p0) >= 18}, 32'd1);

        repeat (20) cycle(100, 0);
        check("full_req", {31'b0, ibus.ibus_req_o}, 32'd0);
        check("full_count", 32'(dut.count), DEPTH);

        p0 = n_pops;
        repeat (30) cycle(0, 0);
        check("release_rate", {31'b0, (n_pops - p0) >= 12}, 32'd1);

        repeat (60) cycle(0, 50);

        gnt_max = 3;
        rv_max = 3;
        p0 = n_pops;
        repeat (2000) cycle(30, 10);
        check("random_rate", {31'b0, (n_pops - p0) >= 200}, 32'd1);

        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            cycle(0, 0);
            found = pend && !pend_stray;
        end
        check("wait_found", {31'b0, found}, 32'd1);
        do_reset();
        p0 = n_pops;
        repeat (200) cycle(20, 0);
        check("post_rst_rate", {31'b0, (n_pops - p0) >= 20}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
